// File: rtl/seven_seg_hex_mux.sv
// Time-multiplexed hex 7-segment driver: per-digit scan with in-slot PWM,
// frame-synchronous shadow commit, decimal points, blanking and leading-zero suppression.
module seven_seg_hex_mux #(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BRIGHT_W       = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*N_DIGITS-1:0]   value_i,
  input  logic [N_DIGITS-1:0]     dp_i,
  input  logic [N_DIGITS-1:0]     blank_i,
  input  logic                    load_i,
  input  logic                    lz_supp_i,
  input  logic [BRIGHT_W-1:0]     bright_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [N_DIGITS-1:0]     an_o,
  output logic                    frame_o
);

  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam int ON_W   = $clog2(SCAN_DIV + 1);
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PROD_W = ON_W + BRIGHT_W;

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [ON_W-1:0]       r_on_cyc;
  logic [4*N_DIGITS-1:0] r_shd_val;
  logic [N_DIGITS-1:0]   r_shd_dp;
  logic [N_DIGITS-1:0]   r_shd_blank;
  logic [4*N_DIGITS-1:0] r_act_val;
  logic [N_DIGITS-1:0]   r_act_dp;
  logic [N_DIGITS-1:0]   r_act_blank;
  logic                  r_pending;
  logic                  r_frame;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [N_DIGITS-1:0]   r_an;

  logic                  w_slot_end;
  logic                  w_wrap;
  logic                  w_commit;
  logic [PROD_W-1:0]     w_prod;
  logic [ON_W-1:0]       w_on_cyc;
  logic                  w_in_win;
  logic [3:0]            w_nib;
  logic [N_DIGITS-1:0]   w_supp;
  logic                  w_seg_on;
  logic                  w_dp_on;
  logic [6:0]            w_seg_ah;
  logic [N_DIGITS-1:0]   w_an_ah;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  assign w_slot_end = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_wrap     = w_slot_end && (r_idx == IDX_W'(N_DIGITS - 1));
  assign w_commit   = w_wrap && r_pending;

  // Max product is 2**BRIGHT_W * SCAN_DIV, which always fits in PROD_W bits.
  assign w_prod   = (PROD_W'(bright_i) + PROD_W'(1)) * PROD_W'(SCAN_DIV);
  assign w_on_cyc = ON_W'(w_prod >> BRIGHT_W);

  // cnt==0 is the anti-ghosting dead cycle of every slot.
  assign w_in_win = (r_cnt != '0) && (32'(r_cnt) <= 32'(r_on_cyc));
  assign w_nib    = r_act_val[4*int'(r_idx) +: 4];

  always_comb begin
    w_supp = '0;
    for (int k = 1; k < N_DIGITS; k++) begin
      w_supp[k] = lz_supp_i && ((r_act_val >> (4*k)) == '0);
    end
  end

  // A suppressed digit still enables its anode when only its dp is lit.
  assign w_seg_on = w_in_win && !r_act_blank[r_idx] && !w_supp[r_idx];
  assign w_dp_on  = w_in_win && !r_act_blank[r_idx] && r_act_dp[r_idx];
  assign w_seg_ah = w_seg_on ? f_decode(w_nib) : 7'h00;

  always_comb begin
    w_an_ah        = '0;
    w_an_ah[r_idx] = w_seg_on || w_dp_on;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_on_cyc    <= '0;
      r_shd_val   <= '0;
      r_shd_dp    <= '0;
      r_shd_blank <= '0;
      r_act_val   <= '0;
      r_act_dp    <= '0;
      r_act_blank <= '0;
      r_pending   <= 1'b0;
      r_frame     <= 1'b0;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + CNT_W'(1);
      if (w_slot_end) begin
        r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
      end
      if (r_cnt == '0) begin
        r_on_cyc <= w_on_cyc;
      end
      r_frame <= w_commit;
      if (w_commit) begin
        r_act_val   <= r_shd_val;
        r_act_dp    <= r_shd_dp;
        r_act_blank <= r_shd_blank;
      end
      // A load on the commit cycle lands in shadow and keeps pending set.
      if (load_i) begin
        r_shd_val   <= value_i;
        r_shd_dp    <= dp_i;
        r_shd_blank <= blank_i;
        r_pending   <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
      r_dp  <= (SEG_ACTIVE_LOW != 0);
      r_an  <= (DIG_ACTIVE_LOW != 0) ? '1 : '0;
    end else begin
      r_seg <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_ah : w_seg_ah;
      r_dp  <= (SEG_ACTIVE_LOW != 0) ? !w_dp_on : w_dp_on;
      r_an  <= (DIG_ACTIVE_LOW != 0) ? ~w_an_ah : w_an_ah;
    end
  end

  assign seg_o   = r_seg;
  assign dp_o    = r_dp;
  assign an_o    = r_an;
  assign frame_o = r_frame;

endmodule

// File: tb/tb_seven_seg_hex_mux.sv
// Scoreboard bench for seven_seg_hex_mux: a time-based reference model predicts
// every output cycle; a monitor pops predictions and compares them with the pins.
module tb_seven_seg_hex_mux;

  localparam int N  = 4;
  localparam int SD = 16;
  localparam int BW = 2;
  localparam int FRAME = N * SD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   value_i = '0;
  logic [3:0]    dp_i = '0;
  logic [3:0]    blank_i = '0;
  logic          load_i = 1'b0;
  logic          lz_supp_i = 1'b0;
  logic [BW-1:0] bright_i = '0;
  logic [6:0]    seg_o;
  logic          dp_o;
  logic [3:0]    an_o;
  logic          frame_o;

  seven_seg_hex_mux #(
    .N_DIGITS(N), .SCAN_DIV(SD), .BRIGHT_W(BW), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .value_i(value_i), .dp_i(dp_i), .blank_i(blank_i),
    .load_i(load_i), .lz_supp_i(lz_supp_i), .bright_i(bright_i),
    .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: time since reset plus the committed/shadow picture.
  int          m_t;
  int          m_on;
  logic [15:0] m_shd_val, m_act_val;
  logic [3:0]  m_shd_dp, m_act_dp, m_shd_blank, m_act_blank;
  bit          m_pending;

  // Predict the outputs after the coming posedge from current inputs, then wait a cycle.
  task automatic step();
    exp_t e;
    int   cnt, dig, nib;
    bit   lit, supp, seg_on, dp_on;
    if (rst) begin
      e = '{7'h7F, 1'b1, 4'hF, 1'b0};
      m_t = 0; m_on = 0; m_pending = 0;
      m_shd_val = '0; m_act_val = '0;
      m_shd_dp = '0; m_act_dp = '0; m_shd_blank = '0; m_act_blank = '0;
    end else begin
      cnt    = m_t % SD;
      dig    = (m_t / SD) % N;
      nib    = int'((m_act_val >> (4*dig)) & 16'hF);
      lit    = (cnt >= 1) && (cnt <= m_on);
      supp   = lz_supp_i && (dig > 0) && ((m_act_val >> (4*dig)) == 16'h0);
      seg_on = lit && !m_act_blank[dig] && !supp;
      dp_on  = lit && !m_act_blank[dig] && m_act_dp[dig];
      e.seg   = seg_on ? ~segtab[nib] : 7'h7F;
      e.dp    = !dp_on;
      e.an    = (seg_on || dp_on) ? ~(4'b0001 << dig) : 4'hF;
      e.frame = ((m_t % FRAME) == FRAME - 1) && m_pending;
      if (cnt == 0) m_on = ((int'(bright_i) + 1) * SD) >> BW;
      if (e.frame) begin
        m_act_val = m_shd_val; m_act_dp = m_shd_dp; m_act_blank = m_shd_blank;
        m_pending = 0;
      end
      if (load_i) begin
        m_shd_val = value_i; m_shd_dp = dp_i; m_shd_blank = blank_i;
        m_pending = 1;
      end
      m_t++;
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    value_i = v; dp_i = dp; blank_i = bl; load_i = 1'b1;
    step();
    load_i = 1'b0;
  endtask

  task automatic wait_phase(input int period, input int phase);
    for (int i = 0; i < FRAME && (m_t % period) != phase; i++) step();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks += 4;
        if (seg_o !== e.seg) begin
          errors++; $display("FAIL seg t=%0t got %h exp %h", $time, seg_o, e.seg);
        end
        if (dp_o !== e.dp) begin
          errors++; $display("FAIL dp t=%0t got %b exp %b", $time, dp_o, e.dp);
        end
        if (an_o !== e.an) begin
          errors++; $display("FAIL an t=%0t got %b exp %b", $time, an_o, e.an);
        end
        if (frame_o !== e.frame) begin
          errors++; $display("FAIL frame t=%0t got %b exp %b", $time, frame_o, e.frame);
        end
      end
    end
  end

  initial begin : stimulus
    // 1: reset then idle, no commits expected
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(64);

    // 2: full brightness, value 12AF
    bright_i = 2'd3;
    load(16'h12AF, 4'h0, 4'h0);
    run(3 * FRAME);

    // 3: minimum brightness
    bright_i = 2'd0;
    run(2 * FRAME);

    // 4: leading-zero suppression with dp on a suppressed digit
    bright_i = 2'd2;
    lz_supp_i = 1'b1;
    load(16'h0040, 4'b1000, 4'h0);
    run(2 * FRAME);
    lz_supp_i = 1'b0;
    run(FRAME);

    // 5: mid-frame load, then a load exactly on the commit cycle
    bright_i = 2'd3;
    wait_phase(FRAME, 20);
    load(16'h3C5D, 4'b0101, 4'h0);
    wait_phase(FRAME, FRAME - 1);
    load(16'h9E07, 4'b0010, 4'h0);
    run(3 * FRAME);

    // 6: blanked digit with dp, then reset mid-slot
    load(16'h4321, 4'b0001, 4'b0001);
    run(2 * FRAME + 5);
    wait_phase(SD, 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(FRAME + 10);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bright_i = BW'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) lz_supp_i = ~lz_supp_i;
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 24) == 0) begin
        value_i = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp_i    = 4'($urandom);
        blank_i = 4'($urandom & $urandom);
        load_i  = 1'b1;
      end else begin
        load_i = 1'b0;
      end
      step();
    end
    rst = 1'b0;
    load_i = 1'b0;
    run(4);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending predictions exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
